// File: rtl/ecall_io_ctrl.sv
// ecall_io_ctrl: services CPU ecalls with board I/O.
//   a7=5  read int  : wait for a debounced confirm press, write sign-extended
//                     switches into a0 through a register-file write port.
//   a7=1  print int : show a0 on the display, wait for a confirm press.
//   a7=10 exit      : freeze the CPU until reset.
// The confirm button is synchronized, debounced, and edge-detected locally.
module ecall_io_ctrl #(
    parameter int unsigned DB_CYCLES = 1_000_000,
    parameter logic [4:0]  A0_ADDR   = 5'd10
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ecall_valid,
    input  logic [31:0] a7_data,
    input  logic [31:0] a0_data,
    input  logic        conf_btn,
    input  logic [12:0] switch_data,
    output logic        stall,
    output logic        io_we,
    output logic [4:0]  io_waddr,
    output logic [31:0] io_wdata,
    output logic [31:0] disp_data,
    output logic        halted,
    output logic        done
);

    localparam int unsigned CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_REL,
        S_WAIT_PRESS,
        S_WRITE,
        S_DONE,
        S_HALT
    } state_e;

    state_e          state_q;
    logic [3:0]      code_q;
    logic [1:0]      sync_q;
    logic            db_q, db_d;
    logic            db_prev_q;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic            io_we_q, halted_q, done_q;
    logic [31:0]     io_wdata_q, disp_q;
    logic            press;
    logic            svc_call;

    // Two-flop synchronizer for the asynchronous button.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sync_q <= 2'b00;
        else       sync_q <= {sync_q[0], conf_btn};
    end

    // Debounce next state: flip only after DB_CYCLES consecutive disagreeing cycles.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        if (sync_q[1] != db_q) begin
            if (db_cnt_q == CNT_LAST) begin
                db_d = sync_q[1];
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Debounce state and previous level for rising-edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            db_q      <= 1'b0;
            db_cnt_q  <= '0;
            db_prev_q <= 1'b0;
        end else begin
            db_q      <= db_d;
            db_cnt_q  <= db_cnt_d;
            db_prev_q <= db_q;
        end
    end

    assign press    = db_q & ~db_prev_q;
    assign svc_call = (a7_data == 32'd5) || (a7_data == 32'd1) || (a7_data == 32'd10);

    // Service FSM with registered write, done and halt outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            code_q     <= 4'd0;
            io_we_q    <= 1'b0;
            io_wdata_q <= 32'd0;
            disp_q     <= 32'd0;
            halted_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (ecall_valid) begin
                        code_q <= a7_data[3:0];
                        if (a7_data == 32'd5) begin
                            state_q <= S_WAIT_REL;
                        end else if (a7_data == 32'd1) begin
                            disp_q  <= a0_data;
                            state_q <= S_WAIT_REL;
                        end else if (a7_data == 32'd10) begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end
                    end
                end
                S_WAIT_REL: begin
                    // A button still held from an earlier call must be let go first.
                    if (!db_q) state_q <= S_WAIT_PRESS;
                end
                S_WAIT_PRESS: begin
                    if (press) begin
                        if (code_q == 4'd5) begin
                            io_wdata_q <= {{19{switch_data[12]}}, switch_data};
                            io_we_q    <= 1'b1;
                            state_q    <= S_WRITE;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_WRITE: begin
                    io_we_q <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_HALT: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // The IDLE term freezes the PC in the ecall cycle itself.
    assign stall = ((state_q == S_IDLE) && ecall_valid && svc_call)
                 || (state_q == S_WAIT_REL) || (state_q == S_WAIT_PRESS)
                 || (state_q == S_WRITE)    || (state_q == S_HALT);

    assign io_we     = io_we_q;
    assign io_waddr  = A0_ADDR;
    assign io_wdata  = io_wdata_q;
    assign disp_data = disp_q;
    assign halted    = halted_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ecall_io_ctrl.sv
// Testbench for ecall_io_ctrl: directed ecalls, scoreboard-checked write/done events.
module tb_ecall_io_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ecall_valid = 1'b0;
    logic [31:0] a7_data = 32'd0;
    logic [31:0] a0_data = 32'd0;
    logic        conf_btn = 1'b0;
    logic [12:0] switch_data = 13'd0;
    logic        stall, io_we, halted, done;
    logic [4:0]  io_waddr;
    logic [31:0] io_wdata, disp_data;

    ecall_io_ctrl #(.DB_CYCLES(4), .A0_ADDR(5'd10)) dut (
        .clk(clk), .rstn(rstn), .ecall_valid(ecall_valid), .a7_data(a7_data),
        .a0_data(a0_data), .conf_btn(conf_btn), .switch_data(switch_data),
        .stall(stall), .io_we(io_we), .io_waddr(io_waddr), .io_wdata(io_wdata),
        .disp_data(disp_data), .halted(halted), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_wr;
        logic        after_wr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   we_cyc = -100;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // One-cycle ecall; st returns stall as seen during the ecall cycle.
    task automatic ecall(input logic [31:0] a7, input logic [31:0] a0, output logic st);
        ecall_valid = 1'b1;
        a7_data     = a7;
        a0_data     = a0;
        #1;
        st = stall;
        tick();
        ecall_valid = 1'b0;
    endtask

    task automatic press_btn(input int hold);
        conf_btn = 1'b1;
        ticks(hold);
        conf_btn = 1'b0;
        ticks(10);
    endtask

    task automatic do_read(input logic [12:0] sw_early, input logic [12:0] sw, input logic [31:0] exp);
        logic st;
        int   d0;
        sb.push_back('{is_wr: 1'b1, after_wr: 1'b0, data: exp});
        sb.push_back('{is_wr: 1'b0, after_wr: 1'b1, data: 32'd0});
        switch_data = sw_early;
        d0 = done_cnt;
        ecall(32'd5, 32'd0, st);
        check("read_stall_ecall", st, 1);
        check("read_stall_wait", stall, 1);
        switch_data = sw;
        press_btn(10);
        check("read_done_cnt", done_cnt, d0 + 1);
        check("read_stall_after", stall, 0);
        check("read_wdata_hold", io_wdata, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard whenever the DUT writes or completes.
    always @(negedge clk) begin
        if (rstn) begin
            if (io_we) begin
                if (sb.size() == 0 || !sb[0].is_wr) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got data %h, no write expected", io_wdata);
                end else begin
                    mon_e = sb.pop_front();
                    check("wr_data", io_wdata, mon_e.data);
                    check("wr_addr", 32'(io_waddr), 32'd10);
                    check("wr_stall", 32'(stall), 32'd1);
                    we_cyc = cyc;
                end
            end
            if (done) begin
                done_cnt++;
                if (sb.size() == 0 || sb[0].is_wr) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done, queue size %0d", sb.size());
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.after_wr) check("done_latency", 32'(cyc - we_cyc), 32'd1);
                    check("done_stall", 32'(stall), 32'd0);
                end
            end
        end
    end

    initial begin
        logic st;
        logic ok;
        int   d0;

        // Reset state.
        #3;
        check("rst_stall", stall, 0);
        check("rst_we", io_we, 0);
        check("rst_wdata", io_wdata, 0);
        check("rst_disp", disp_data, 0);
        check("rst_halted", halted, 0);
        check("rst_done", done, 0);
        ticks(2);
        rstn = 1'b1;
        ticks(2);

        // Read-int: positive, all-ones, and sign bit only.
        do_read(13'h0155, 13'h007B, 32'h0000_007B);
        do_read(13'h0000, 13'h1FFF, 32'hFFFF_FFFF);
        do_read(13'h0FFF, 13'h1000, 32'hFFFF_F000);

        // Print-int.
        sb.push_back('{is_wr: 1'b0, after_wr: 1'b0, data: 32'd0});
        d0 = done_cnt;
        ecall(32'd1, 32'h1234_5678, st);
        check("print_stall_ecall", st, 1);
        check("print_disp", disp_data, 32'h1234_5678);
        ticks(8);
        check("print_stall_hold", stall, 1);
        check("print_no_done", done_cnt, d0);
        press_btn(10);
        check("print_done_cnt", done_cnt, d0 + 1);
        check("print_disp_keep", disp_data, 32'h1234_5678);
        check("print_wdata_keep", io_wdata, 32'hFFFF_F000);

        // Button held before the ecall, then a short glitch, then a real press.
        conf_btn = 1'b1;
        ticks(10);
        sb.push_back('{is_wr: 1'b1, after_wr: 1'b0, data: 32'h0000_00AA});
        sb.push_back('{is_wr: 1'b0, after_wr: 1'b1, data: 32'd0});
        switch_data = 13'h00AA;
        d0 = done_cnt;
        ecall(32'd5, 32'd0, st);
        ticks(15);
        check("held_no_done", done_cnt, d0);
        check("held_stall", stall, 1);
        conf_btn = 1'b0;
        ticks(10);
        check("release_no_done", done_cnt, d0);
        press_btn(2);
        check("glitch_no_done", done_cnt, d0);
        check("glitch_stall", stall, 1);
        press_btn(10);
        check("held_done_cnt", done_cnt, d0 + 1);

        // Unserviced code.
        d0 = done_cnt;
        ecall(32'd7, 32'd0, st);
        check("a7_7_stall_ecall", st, 0);
        check("a7_7_stall", stall, 0);
        press_btn(10);
        check("a7_7_no_done", done_cnt, d0);

        // Reset during a pending read: no write, back to idle.
        ecall(32'd5, 32'd0, st);
        ticks(3);
        check("abort_stall_pre", stall, 1);
        rstn = 1'b0;
        #1;
        check("abort_stall", stall, 0);
        check("abort_disp", disp_data, 0);
        ticks(2);
        rstn = 1'b1;
        d0 = done_cnt;
        press_btn(10);
        check("abort_no_done", done_cnt, d0);
        check("abort_idle_stall", stall, 0);
        do_read(13'h0000, 13'h0001, 32'h0000_0001);

        // Exit: permanent halt, cleared only by reset.
        d0 = done_cnt;
        ecall(32'd10, 32'd0, st);
        check("halt_stall_ecall", st, 1);
        ok = 1'b1;
        for (int i = 0; i < 120; i++) begin
            conf_btn = ((i / 8) % 2) == 1;
            if (!(stall && halted)) ok = 1'b0;
            tick();
        end
        conf_btn = 1'b0;
        check("halt_hold", ok, 1);
        check("halt_no_done", done_cnt, d0);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check("halt_rst_halted", halted, 0);
        check("halt_rst_stall", stall, 0);
        check("halt_rst_wdata", io_wdata, 0);
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish before time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ecall_io_ctrl.md
Name: ecall_io_ctrl

Overview:
- Writer-side counterpart to the register file's switch/button debug read path.
- Services CPU ecall instructions using board I/O:
  - a7=5 (read int): waits for a debounced confirm press, then writes the sign-extended switch value into a0 through a register-file write port.
  - a7=1 (print int): latches a0 onto the display and waits for confirm.
  - a7=10 (exit): halts the CPU.
- Sits between the decode/execute stage, the register file's write-port mux, and the board switches, buttons and LEDs.

Parameters:
DB_CYCLES, 1_000_000, consecutive stable cycles required for the debounced button to change state (use 4 in simulation)
A0_ADDR, 5'd10, destination register for read-int

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
ecall_valid  in  1  high for one cycle when an ecall is in execute
a7_data  in  32  current register x17
a0_data  in  32  current register x10
conf_btn  in  1  raw confirm button, asynchronous, active-high
switch_data  in  13  board switches
stall  out  1  freezes PC and pipeline while high
io_we  out  1  register-file write enable from this block
io_waddr  out  5  write address, constant A0_ADDR
io_wdata  out  32  write data
disp_data  out  32  value shown on the LEDs/7-seg for print-int
halted  out  1  sticky high after exit
done  out  1  one-cycle pulse when a serviced ecall completes

Behaviour:
- Reset (async, rstn=0): state=IDLE; stall=0, io_we=0, io_wdata=0, disp_data=0, halted=0, done=0; synchronizer, debounce counter and latched code cleared. Reset asserted mid-operation aborts any ecall and performs no write.
- Button conditioning:
  - conf_btn passes through a 2-FF synchronizer.
  - The debounced level db_btn changes only after the synchronized value differs from db_btn for DB_CYCLES consecutive cycles. The counter clears whenever the values match.
  - press = rising edge of db_btn, a one-cycle pulse.
- Stall: stall = (state==IDLE and ecall_valid and a7_data in {1,5,10}) or state in {WAIT_REL, WAIT_PRESS, WRITE, HALT}. The combinational term freezes the PC in the ecall cycle itself.
- FSM:
  - IDLE:
    - On ecall_valid, latch code=a7_data[3:0].
    - a7=5 -> WAIT_REL.
    - a7=1 -> disp_data<=a0_data, then WAIT_REL.
    - a7=10 -> HALT.
    - Any other a7: no stall, no state change, no done.
  - WAIT_REL: stay until db_btn==0, so a button held from a previous ecall cannot confirm this one; then -> WAIT_PRESS.
  - WAIT_PRESS: on press:
    - Read: capture io_wdata <= sign-extension of switch_data[12:0] (bit 12 copied into [31:13]), then -> WRITE.
    - Print: -> DONE.
    - Switch changes before the press are ignored; the value is sampled in the press cycle.
  - WRITE: io_we=1 for exactly one cycle (address A0_ADDR, data io_wdata), stall=1; -> DONE.
  - DONE: stall=0, done=1 for one cycle, ecall_valid ignored; -> IDLE. The CPU advances past the ecall here, so the new a0 is visible to the next instruction.
  - HALT: halted=1, stall=1 permanently; leaves only via reset.
- Output persistence: disp_data holds its value until the next print-int; io_wdata holds after the write; io_we is 0 outside WRITE.
- Write conflicts: the CPU must not write the register file while stall=1, so io_we never conflicts with a CPU write.
- Latency, read-int: ecall cycle -> WAIT_REL (1 cycle minimum) -> press -> WRITE -> DONE. The write occurs exactly 1 cycle after the press pulse, and done 2 cycles after it.

Test Plan:
- DB_CYCLES=4, button released, ecall_valid with a7=5, switches=13'h0_07B, press held 10 cycles -> io_we pulses once 1 cycle after the press pulse, io_waddr=10, io_wdata=32'h0000_007B, done one cycle later, stall low from DONE onward.
- Read-int with switches=13'h1FFF -> io_wdata=32'hFFFF_FFFF. Switches=13'h1000 -> 32'hFFFF_F000.
- a7=1, a0=32'h1234_5678 -> disp_data=32'h1234_5678 from the cycle after ecall; stall held until press; no io_we; done pulse; disp_data retained afterwards.
- Button held down before the ecall -> no completion until release plus a new press. A 2-cycle glitch (less than DB_CYCLES) produces no press.
- a7=10 -> stall and halted stay 1 for more than 100 cycles regardless of the button; rstn low -> everything returns to 0 immediately (asynchronously).
- a7=7 -> stall never asserts, no done, no write. Reset asserted during WAIT_PRESS with a read pending -> no io_we; state=IDLE after release.
